// File: rtl/somador_bcd_pkg.sv
// Shared constants for the single-digit BCD adder: active-low 7-segment
// patterns in {g,f,e,d,c,b,a} order and the largest legal BCD digit.
package somador_bcd_pkg;

  localparam int BCD_MAX = 9;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Map an active-low pattern onto the board's segment polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_n,
                                              input bit        active_low);
    return active_low ? seg_n : ~seg_n;
  endfunction

endpackage

// File: rtl/somador_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder; non-decimal codes
// and the invalid flag both show "E".
module bcd_to_7seg
  import somador_bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       invalid,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_E;
    if (!invalid) begin
      unique case (digit)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/somador_bcd.sv
// Single-digit BCD adder: a + b + cin[0] with +6 decimal correction, units
// digit registered as a 7-segment pattern alongside the decimal carry.
module somador_bcd
  import somador_bcd_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] cin,
  output logic       cout,
  output logic [6:0] hex
);

  localparam logic [6:0] HEX_BLANK = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW);

  logic [4:0] bin;
  logic [3:0] digit;
  logic       carry;
  logic       invalid;
  logic [6:0] seg_n;
  logic       cout_d, cout_q;
  logic [6:0] hex_d, hex_q;

  // Only the LSB of the carry-in bus is meaningful.
  logic unused_cin;
  assign unused_cin = ^cin[3:1];

  always_comb begin
    bin     = {1'b0, a} + {1'b0, b} + {4'b0000, cin[0]};
    invalid = (a > 4'(BCD_MAX)) || (b > 4'(BCD_MAX));
    if (bin > 5'(BCD_MAX)) begin
      // bin is 10..19 here, so the low nibble of bin+6 is bin-10.
      digit = bin[3:0] + 4'd6;
      carry = 1'b1;
    end else begin
      digit = bin[3:0];
      carry = 1'b0;
    end
  end

  bcd_to_7seg u_seg (
    .digit   (digit),
    .invalid (invalid),
    .seg_n   (seg_n)
  );

  always_comb begin
    cout_d = carry & ~invalid;
    hex_d  = seg_polarity(seg_n, SEG_ACTIVE_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      hex_q  <= HEX_BLANK;
    end else begin
      cout_q <= cout_d;
      hex_q  <= hex_d;
    end
  end

  assign cout = cout_q;
  assign hex  = hex_q;

endmodule

// File: tb/tb_somador_bcd.sv
// Scoreboarded bench for somador_bcd: driver pushes expected outputs computed
// with plain decimal arithmetic, monitor compares both polarity builds.
module tb_somador_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0, b = '0, cin = '0;
  logic       cout_lo, cout_hi;
  logic [6:0] hex_lo, hex_hi;

  always #5 clk = ~clk;

  somador_bcd #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .cout(cout_lo), .hex(hex_lo)
  );

  somador_bcd #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .cout(cout_hi), .hex(hex_hi)
  );

  typedef struct {
    logic       cout;
    logic [6:0] hex_n;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Active-low {g..a} patterns for decimal digits 0..9.
  logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  localparam logic [6:0] E_PAT     = 7'b0000110;
  localparam logic [6:0] BLANK_PAT = 7'b1111111;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic exp_t model(input logic r, input int ai, input int bi,
                                 input int ci, input string tag);
    exp_t e;
    int   s;
    e.tag = tag;
    if (r) begin
      e.cout = 1'b0; e.hex_n = BLANK_PAT;
    end else if (ai > 9 || bi > 9) begin
      e.cout = 1'b0; e.hex_n = E_PAT;
    end else begin
      s       = ai + bi + (ci % 2);
      e.cout  = (s >= 10);
      e.hex_n = seg_tbl[s % 10];
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] cv, input string tag);
    @(negedge clk);
    rst = r; a = av; b = bv; cin = cv;
    q.push_back(model(r, int'(av), int'(bv), int'(cv), tag));
  endtask

  // Monitor: one result per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".cout_lo"}, {6'b0, cout_lo}, {6'b0, e.cout});
        check({e.tag, ".hex_lo"},  hex_lo, e.hex_n);
        check({e.tag, ".cout_hi"}, {6'b0, cout_hi}, {6'b0, e.cout});
        check({e.tag, ".hex_hi"},  hex_hi, ~e.hex_n);
      end
    end
  end

  initial begin
    int budget;
    drive(1'b1, 4'd1, 4'd2, 4'd1, "reset0");
    drive(1'b1, 4'd9, 4'd9, 4'd1, "reset1");
    drive(1'b0, 4'd3, 4'd4, 4'd0, "add_3_4");
    drive(1'b0, 4'd6, 4'd7, 4'd0, "add_6_7");
    drive(1'b0, 4'd7, 4'd9, 4'd0, "add_7_9");
    drive(1'b0, 4'd9, 4'd9, 4'b0001, "sum19");
    drive(1'b0, 4'd5, 4'd4, 4'd1, "sum10");
    drive(1'b0, 4'd4, 4'd5, 4'd0, "sum9");
    drive(1'b0, 4'd2, 4'd2, 4'b1110, "cin_hi_ignored");
    drive(1'b0, 4'd12, 4'd1, 4'd0, "inv_a");
    drive(1'b0, 4'd0, 4'd15, 4'd1, "inv_b");
    drive(1'b0, 4'd6, 4'd7, 4'd0, "pre_rst");
    drive(1'b1, 4'd6, 4'd7, 4'd0, "mid_rst");
    drive(1'b0, 4'd6, 4'd7, 4'd0, "post_rst");

    for (int ai = 0; ai <= 9; ai++)
      for (int bi = 0; bi <= 9; bi++)
        for (int ci = 0; ci <= 1; ci++)
          drive(1'b0, 4'(ai), 4'(bi), {3'($urandom_range(0, 7)), 1'(ci)}, "sweep");

    for (int i = 0; i < 60; i++)
      drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");

    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/somador_bcd.md
Name: somador_bcd

Overview:
- Single-digit BCD adder with a registered 7-segment output.
- Adds two BCD digits plus a carry-in, applies the +6 decimal correction, and registers the units digit (7-segment encoded) and the decimal carry-out.
- Sits between the board switch inputs and one HEX display plus the carry LED.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segments lit by 0 (DE-series HEX displays); 0 = lit by 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  4  BCD operand A, valid 0-9.
- b  input  4  BCD operand B, valid 0-9.
- cin  input  4  carry-in; only cin[0] is used, cin[3:1] ignored.
- cout  output  1  registered decimal carry-out (sum >= 10).
- hex  output  7  registered 7-segment pattern of the sum's units digit; bit order {g,f,e,d,c,b,a}, hex[0]=a.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - While rst=1 at an edge: cout <= 0; hex <= blank (all segments off: 7'b1111111 when active-low).
- Arithmetic, combinational, on each cycle:
  - bin = a + b + cin[0], computed 5 bits wide (maximum 9+9+1 = 19).
  - If bin > 9: digit = bin + 6 (low 4 bits), carry = 1.
  - Else: digit = bin[3:0], carry = 0.
- Invalid-input rule:
  - If a > 9 or b > 9: carry = 0 and the display shows "E" (active-low 7'b0000110).
  - This overrides the arithmetic result.
- Registering and latency:
  - On each rising edge with rst=0: cout <= carry; hex <= seg(digit), or the E pattern per the invalid-input rule.
  - Latency is exactly 1 clock from input change to output update.
  - No handshake; inputs are sampled every cycle and outputs hold between edges.
- Segment encodings, active-low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - E=0000110, blank=1111111
  - When SEG_ACTIVE_LOW=0, every pattern is bitwise inverted.
- Boundary conditions:
  - Sum exactly 10: digit 0, cout 1.
  - Sum 19 (9+9+1): digit 9, cout 1.
  - Sum 9: no correction, cout 0.
  - cin[3:1] nonzero has no effect.
- Reset mid-operation: reset wins at that edge; the next non-reset edge produces a valid result for the current inputs.
- No latches; all outputs come directly from flip-flops.

Decomposition:
- Package somador_bcd_pkg:
  - 7-bit segment constants SEG_0 through SEG_9, SEG_E, SEG_BLANK (active-low form).
  - Localparam BCD_MAX = 9.
- One sub-module: bcd_to_7seg.
  - Purely combinational: 4-bit digit plus invalid flag -> 7-bit active-low pattern.
  - Codes 10-15 map to SEG_E.
  - Polarity inversion is applied in the top level.
- Top level holds the adder, the correction logic and the output registers.

Test Plan:
- rst=1 for 2 cycles with any inputs -> cout=0, hex=1111111; release rst, a=3, b=4, cin=0 -> after 1 edge cout=0, hex=1111000 ("7").
- a=6, b=7, cin=0 -> after 1 edge cout=1, hex=0110000 ("3", sum 13); outputs unchanged before that edge.
- a=7, b=9, cin=0 -> cout=1, hex=0000010 ("6", sum 16); then a=9, b=9, cin=4'b0001 -> cout=1, hex=0010000 ("9", sum 19).
- Boundaries:
  - a=5, b=4, cin=1 -> cout=1, hex=1000000 (sum 10).
  - a=4, b=5, cin=0 -> cout=0, hex=0010000 (sum 9).
  - a=2, b=2, cin=4'b1110 -> cout=0, hex=0011001 (cin upper bits ignored).
- Invalid inputs: a=12, b=1 -> cout=0, hex=0000110 ("E"); a=0, b=15 -> same.
- Reset mid-stream: with a=6, b=7 applied, assert rst for one edge -> cout=0, hex=blank; deassert -> next edge cout=1, hex=0110000.
- Exhaustive sweep of all a, b in 0-9 and cin 0/1 against a reference model: digit=(a+b+cin)%10, cout=(a+b+cin)>=10, with 1-cycle latency.
